// File: rtl/uart_print_unit_if.sv
// Request channel of the UART print unit: a valid/ready handshake that carries
// one 32-bit word plus the number of its low-order bytes to print.
interface uart_print_unit_if;
    logic        REQ_VALID;
    logic [31:0] REQ_DATA;
    logic [1:0]  REQ_NBYTES;   // byte count minus one
    logic        REQ_READY;

    modport master (output REQ_VALID, REQ_DATA, REQ_NBYTES, input REQ_READY);
    modport slave  (input REQ_VALID, REQ_DATA, REQ_NBYTES, output REQ_READY);
endinterface

// File: rtl/uart_print_unit.sv
// UART print unit: a packer splits accepted words into bytes (most significant
// selected byte first), a circular byte queue buffers them, and an 8N1
// transmitter serialises them back-to-back onto UART_TX.
// Optional build macro PRINT_PARITY_EN adds an even-parity bit (8E1 frames).
module uart_print_unit #(
    parameter int DEPTH       = 512,  // queue entries, power of two, >= 4
    parameter int CLK_PER_BIT = 868   // clock cycles per UART bit, >= 2
) (
    input  logic                    CLK,
    input  logic                    INITIALIZE_N,
    uart_print_unit_if.slave        req,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    BUSY,
    output logic                    UART_TX
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        PK_IDLE,
        PK_PACK
    } pk_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef PRINT_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    // Packer state
    pk_state_t      pk_state;
    logic [31:0]    pk_data;
    logic [1:0]     pk_idx;     // index of the byte to write next, counts down

    // Queue state
    logic [7:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Transmitter state
    tx_state_t      tx_state;
    logic [CNT_W-1:0] tx_cnt;   // cycles elapsed within the current bit
    logic [2:0]     tx_bit;     // data bit being sent
    logic [7:0]     tx_shift;   // current frame byte, LSB is on the line
`ifdef PRINT_PARITY_EN
    logic           tx_par;
`endif

    logic           full;
    logic           empty;
    logic           wr_en;
    logic [7:0]     wr_byte;
    logic           bit_end;
    logic           pop;
    logic [7:0]     rd_byte;

    assign full    = (LEVEL == LEVEL_FULL);
    assign empty   = (LEVEL == '0);
    assign wr_en   = (pk_state == PK_PACK) && !full;
    assign wr_byte = pk_data[{pk_idx, 3'b000} +: 8];
    assign bit_end = (tx_cnt == CNT_LAST);
    assign rd_byte = mem[rd_ptr];

    // A byte leaves the queue when the line is free, or in the last cycle of
    // a stop bit so the next start bit follows with no idle gap.
    assign pop = !empty && ((tx_state == TX_IDLE) ||
                            ((tx_state == TX_STOP) && bit_end));

    assign req.REQ_READY = (pk_state == PK_IDLE);
    assign BUSY = (pk_state != PK_IDLE) || !empty || (tx_state != TX_IDLE);

    // Packer: latch a request, then emit its bytes one per cycle while the
    // queue has room.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            pk_state <= PK_IDLE;
            pk_data  <= '0;
            pk_idx   <= '0;
        end else begin
            case (pk_state)
                PK_IDLE: begin
                    if (req.REQ_VALID) begin
                        pk_data  <= req.REQ_DATA;
                        pk_idx   <= req.REQ_NBYTES;
                        pk_state <= PK_PACK;
                    end
                end
                PK_PACK: begin
                    if (!full) begin
                        if (pk_idx == 2'd0) begin
                            pk_state <= PK_IDLE;
                        end else begin
                            pk_idx <= pk_idx - 2'd1;
                        end
                    end
                end
                default: pk_state <= PK_IDLE;
            endcase
        end
    end

    // Queue storage write port.
    // NOTE: the RAM has no reset; emptiness is tracked by LEVEL, so stale
    // contents are never read and the array can map onto plain memory.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_byte;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   LEVEL <= LEVEL + 1'b1;
                2'b01:   LEVEL <= LEVEL - 1'b1;
                default: LEVEL <= LEVEL;
            endcase
        end
    end

    // Transmitter: start, 8 data bits LSB-first, optional parity, stop; each
    // bit held for CLK_PER_BIT cycles and driven straight from a flop.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            UART_TX  <= 1'b1;
`ifdef PRINT_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (pop) begin
                        tx_shift <= rd_byte;
`ifdef PRINT_PARITY_EN
                        tx_par   <= ^rd_byte;
`endif
                        UART_TX  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        UART_TX  <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
`ifdef PRINT_PARITY_EN
                            UART_TX  <= tx_par;
                            tx_state <= TX_PARITY;
`else
                            UART_TX  <= 1'b1;
                            tx_state <= TX_STOP;
`endif
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            UART_TX  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef PRINT_PARITY_EN
                TX_PARITY: begin
                    if (bit_end) begin
                        tx_cnt   <= '0;
                        UART_TX  <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (bit_end) begin
                        tx_cnt <= '0;
                        if (pop) begin
                            tx_shift <= rd_byte;
`ifdef PRINT_PARITY_EN
                            tx_par   <= ^rd_byte;
`endif
                            UART_TX  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    UART_TX  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_print_unit.md
UART_PRINT_UNIT -- requirements
Module: uart_print_unit

Interface
REQ-001 SHALL provide parameter DEPTH, default 512, byte-queue entries, power of two, >= 4.
REQ-002 SHALL provide parameter CLK_PER_BIT, default 868, clock cycles per UART bit, >= 2.
REQ-003 SHALL provide port CLK  input  1  system clock, all state on rising edge.
REQ-004 SHALL provide port INITIALIZE_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL provide port REQ_VALID  input  1  print request valid.
REQ-006 SHALL provide port REQ_DATA  input  32  word to print.
REQ-007 SHALL provide port REQ_NBYTES  input  2  byte count minus one (0 = 1 byte ... 3 = 4 bytes).
REQ-008 SHALL provide port REQ_READY  output  1  request accepted when REQ_VALID && REQ_READY at a rising edge.
REQ-009 SHALL provide port LEVEL  output  $clog2(DEPTH)+1  queued byte count.
REQ-010 SHALL provide port BUSY  output  1  packer, queue or transmitter active.
REQ-011 SHALL provide port UART_TX  output  1  serial line, idle high.

Function
REQ-012 Packer SHALL have states IDLE and PACK; REQ_READY = (state == IDLE), combinational from state only.
REQ-013 On acceptance the packer SHALL latch REQ_DATA and REQ_NBYTES and enter PACK.
REQ-014 In PACK the packer SHALL write one byte per cycle, MSB-first among the selected bytes: n bytes -> DATA[8n-1:8n-8] first, DATA[7:0] last.
REQ-015 Queue full in PACK -> packer SHALL hold the current byte without writing; no byte dropped or duplicated.
REQ-016 Packer SHALL return to IDLE on the edge that writes its last byte; the next request is accepted one cycle later at the earliest.
REQ-017 Queue SHALL be circular, DEPTH entries, wrap-around read/write pointers; full when LEVEL == DEPTH, empty when LEVEL == 0.
REQ-018 Simultaneous write and pop SHALL leave LEVEL unchanged; write when full and pop when empty SHALL never occur.
REQ-019 Transmitter SHALL have states IDLE, START, DATA, STOP (plus PARITY, REQ-028); each bit lasts exactly CLK_PER_BIT cycles.
REQ-020 Transmitter in IDLE with queue non-empty SHALL pop one byte and drive UART_TX low (start bit) on the same edge.
REQ-021 DATA SHALL send 8 bits LSB-first; STOP SHALL drive 1 for one bit time, then return to IDLE.
REQ-022 Back-to-back frames SHALL have no idle gap: pop in the STOP-to-IDLE cycle, start bit on the following edge.
REQ-023 Latency: request accepted at edge E -> first byte written at E+1, popped at E+2, UART_TX low after E+2.
REQ-024 BUSY SHALL be high when packer != IDLE or LEVEL != 0 or transmitter != IDLE.
REQ-025 UART_TX SHALL be driven from a flip-flop (glitch-free).

Reset
REQ-026 INITIALIZE_N low SHALL immediately force: packer IDLE, pointers 0, LEVEL 0, transmitter IDLE, bit counters 0, UART_TX 1, BUSY 0, REQ_READY 1.
REQ-027 Reset mid-frame or mid-PACK SHALL discard all pending bytes; queue RAM contents need no reset.

Configuration
REQ-028 Macro PRINT_PARITY_EN defined: transmitter SHALL insert an even-parity bit (XOR of 8 data bits) between DATA and STOP, frame = 11 bit times.
REQ-029 Macro PRINT_PARITY_EN undefined: no PARITY state, frame = 10 bit times (8N1).

Verification (DEPTH=8, CLK_PER_BIT=4, parity off unless stated)
REQ-030 Single request DATA=0x00000041, NBYTES=0 -> UART_TX low after E+2, then bits 1,0,0,0,0,0,1,0, stop 1; 40 cycles per frame; BUSY falls after stop bit.
REQ-031 DATA=0x11223344, NBYTES=3 -> bytes 0x11,0x22,0x33,0x44 in that order, back-to-back, no idle gap between frames.
REQ-032 Three 4-byte requests back-to-back -> queue fills to LEVEL=8, packer holds, REQ_READY low until done; all 12 bytes emitted in order across pointer wrap.
REQ-033 Assert INITIALIZE_N low mid-DATA of the second byte -> UART_TX=1, LEVEL=0, BUSY=0 same cycle; after release, new request 0x55 transmitted correctly.
REQ-034 PRINT_PARITY_EN defined, byte 0x07 -> parity bit 1, 44 cycles per frame; byte 0x03 -> parity bit 0.
